imem_loader: RTL

Byte-stream program loader that writes 32-bit instruction words into the CPU's instruction memory over a synchronous write port. It is the writer on the write side of the word-indexed instruction store: it takes a framed byte stream, typically from a UART receiver, assembles little-endian words and emits one write per word at byte addresses 0, 4, 8, and so on. It holds the CPU in reset while a load is in progress.

---
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader: frames of SYNC, LEN_LO, LEN_HI, LEN*4 data bytes, optional checksum,
// written as little-endian words into instruction memory. Define LOADER_CHECKSUM_EN for checksum.
module imem_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] Depth = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
`ifdef LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [15:0]       r_len, w_len_nxt;
  logic [ADDR_W:0]   r_idx, w_idx_nxt;
  logic [1:0]        r_bcnt, w_bcnt_nxt;
  logic [23:0]       r_word, w_word_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [31:0]       r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_load_done, w_load_done_nxt;
  logic              r_load_err, w_load_err_nxt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum, w_csum_nxt;
`endif

  logic [15:0]       w_len_rx;
  logic [ADDR_W:0]   w_idx_inc;

  assign w_len_rx  = {rx_data, r_len[7:0]};
  assign w_idx_inc = r_idx + (ADDR_W+1)'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_bcnt_nxt      = r_bcnt;
    w_word_nxt      = r_word;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_hold_nxt  = r_cpu_hold;
    w_load_done_nxt = r_load_done;
    w_load_err_nxt  = r_load_err;
`ifdef LOADER_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif
    if (rx_valid) begin
      case (r_state)
        StIdle, StDone, StErr: begin
          if (rx_data == SYNC_BYTE) begin
            w_state_nxt     = StLenLo;
            w_cpu_hold_nxt  = 1'b1;
            w_load_done_nxt = 1'b0;
            w_load_err_nxt  = 1'b0;
            w_idx_nxt       = '0;
            w_bcnt_nxt      = '0;
`ifdef LOADER_CHECKSUM_EN
            w_csum_nxt      = '0;
`endif
          end
        end
        StLenLo: begin
          w_len_nxt   = {r_len[15:8], rx_data};
          w_state_nxt = StLenHi;
        end
        StLenHi: begin
          w_len_nxt = w_len_rx;
          if (w_len_rx == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt     = StCsum;
`else
            w_state_nxt     = StDone;
            w_cpu_hold_nxt  = 1'b0;
            w_load_done_nxt = 1'b1;
`endif
          end else if (32'(w_len_rx) > Depth) begin
            // Rejected before any write, so the index can never overflow the memory.
            w_state_nxt    = StErr;
            w_load_err_nxt = 1'b1;
          end else begin
            w_state_nxt = StData;
          end
        end
        StData: begin
          w_word_nxt = {rx_data, r_word[23:8]};
          w_bcnt_nxt = r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          w_csum_nxt = r_csum + rx_data;
`endif
          if (r_bcnt == 2'd3) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = {rx_data, r_word};
            w_mem_addr_nxt  = {{(30-ADDR_W){1'b0}}, r_idx[ADDR_W-1:0], 2'b00};
            w_idx_nxt       = w_idx_inc;
            if (16'(w_idx_inc) == r_len) begin
`ifdef LOADER_CHECKSUM_EN
              w_state_nxt     = StCsum;
`else
              w_state_nxt     = StDone;
              w_cpu_hold_nxt  = 1'b0;
              w_load_done_nxt = 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCsum: begin
          if (rx_data == r_csum) begin
            w_state_nxt     = StDone;
            w_cpu_hold_nxt  = 1'b0;
            w_load_done_nxt = 1'b1;
          end else begin
            w_state_nxt    = StErr;
            w_load_err_nxt = 1'b1;
          end
        end
`endif
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_word      <= w_word_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_hold  <= w_cpu_hold_nxt;
      r_load_done <= w_load_done_nxt;
      r_load_err  <= w_load_err_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule
